// File: rtl/axi4_lite_sram_slave_pkg.sv
// Shared response codes and FSM encodings for the AXI4-Lite SRAM responder.
package axi4_lite_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'b00,
        RD_WAIT = 2'b01,
        RD_DATA = 2'b10
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_sram_slave_sram_bytewrite.sv
// 1R1W word SRAM with per-byte write enables and a registered read port.
module sram_bytewrite #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Read samples the array before this edge's write lands, so a same-word collision returns old data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite word SRAM responder with independent read/write FSMs.
// Define AXI_SLV_WAIT_EN to add WAIT_CYCLES of extra read latency via RD_WAIT.
module axi4_lite_sram_slave
    import axi4_lite_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    function automatic logic addr_hit(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    wr_state_t   wr_state, wr_next;
    rd_state_t   rd_state, rd_next;
    logic        aw_held, w_held;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [3:0]  w_strb;
    logic [1:0]  bresp, rresp;
    logic        rvalid;
    logic        wr_commit, rd_fetch;
    logic        aw_hit, ar_hit;
    logic [31:0] aw_off, ar_off, mem_q;

    assign aw_off = aw_addr - BASE_ADDR;
    assign ar_off = ar_addr - BASE_ADDR;
    assign aw_hit = addr_hit(aw_addr);
    assign ar_hit = addr_hit(ar_addr);

    // Write channel: capture AW and W independently, commit once both are held
    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        case (wr_state)
            WR_IDLE: if (aw_held && w_held) begin
                wr_next   = WR_RESP;
                wr_commit = aw_hit;
            end
            WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (S_AXI_AWVALID && !aw_held) aw_held <= 1'b1;
            if (S_AXI_WVALID && !w_held) w_held <= 1'b1;
            if (wr_state == WR_IDLE && aw_held && w_held)
                bresp <= aw_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_state == WR_RESP && S_AXI_BREADY) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (S_AXI_AWVALID && !aw_held) aw_addr <= S_AXI_AWADDR;
        if (S_AXI_WVALID && !w_held) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
        end
        if (rd_state == RD_IDLE && S_AXI_ARVALID) ar_addr <= S_AXI_ARADDR;
    end

`ifdef AXI_SLV_WAIT_EN
    logic [3:0] rd_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_cnt <= 4'd0;
        else if (rd_state == RD_IDLE) rd_cnt <= 4'(WAIT_CYCLES);
        else if (rd_state == RD_WAIT) rd_cnt <= rd_cnt - 4'd1;
    end
`endif

    // Read channel: RD_DATA first issues the array read, then holds the beat until RREADY
    always_comb begin
        rd_next  = rd_state;
        rd_fetch = 1'b0;
        case (rd_state)
            RD_IDLE: if (S_AXI_ARVALID) begin
`ifdef AXI_SLV_WAIT_EN
                rd_next = (WAIT_CYCLES == 0) ? RD_DATA : RD_WAIT;
`else
                rd_next = RD_DATA;
`endif
            end
`ifdef AXI_SLV_WAIT_EN
            RD_WAIT: if (rd_cnt <= 4'd1) rd_next = RD_DATA;
`endif
            RD_DATA: begin
                if (!rvalid) rd_fetch = ar_hit;
                else if (S_AXI_RREADY) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_DATA && !rvalid) begin
                rvalid <= 1'b1;
                rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (rd_state == RD_DATA && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    sram_bytewrite #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_sram (
        .clk   (clk),
        .we    ({4{wr_commit}} & w_strb),
        .waddr (aw_off[2 +: IDX_W]),
        .wdata (w_data),
        .re    (rd_fetch),
        .raddr (ar_off[2 +: IDX_W]),
        .rdata (mem_q)
    );

    assign S_AXI_AWREADY = ~aw_held;
    assign S_AXI_WREADY  = ~w_held;
    assign S_AXI_BVALID  = (wr_state == WR_RESP);
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = (rd_state == RD_IDLE);
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    // Array output is unreset, so it is masked whenever there is no OKAY beat to present
    assign S_AXI_RDATA   = (rvalid && rresp == RESP_OKAY) ? mem_q : 32'h0;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_off, ar_off, 4'(WAIT_CYCLES)};

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Randomized self-checking bench for axi4_lite_sram_slave against a byte-level memory model.
module tb_axi4_lite_sram_slave;

    localparam int DEPTH = 1024;
`ifdef AXI_SLV_WAIT_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;

    axi4_lite_sram_slave #(
        .BASE_ADDR   (32'h0000_0000),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [3:0]  model_bv  [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        return addr < 32'(DEPTH * 4);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr >> 2);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int w;
        if (!in_range(addr)) return;
        w = word_of(addr);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                model_mem[w][8*i +: 8] = data[8*i +: 8];
                model_bv[w][i] = 1'b1;
            end
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input string tag);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs, ok = 1;
        int k = 0, lat = 0;
        logic [1:0] resp0;
        while (!(aw_done && w_done) && k < 40) begin
            @(negedge clk);
            S_AXI_AWADDR  = addr;
            S_AXI_WDATA   = data;
            S_AXI_WSTRB   = strb;
            S_AXI_AWVALID = !aw_done && (k >= aw_dly);
            S_AXI_WVALID  = !w_done && (k >= w_dly);
            if (aw_done && S_AXI_AWREADY) ok = 0;
            if (w_done && S_AXI_WREADY) ok = 0;
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge clk);
            aw_done |= aw_hs;
            w_done  |= w_hs;
            k++;
        end
        check({tag, "_hs"}, 32'(aw_done && w_done), 32'd1);
        check({tag, "_ready_drop"}, 32'(ok), 32'd1);
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        while (!S_AXI_BVALID && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_b_lat"}, 32'(lat), 32'd1);
        check({tag, "_bresp"}, 32'(S_AXI_BRESP), in_range(addr) ? 32'd0 : 32'd2);
        resp0 = S_AXI_BRESP;
        repeat (b_dly) begin
            @(negedge clk);
            if (!(S_AXI_BVALID && S_AXI_BRESP == resp0 && !S_AXI_AWREADY && !S_AXI_WREADY)) ok = 0;
        end
        check({tag, "_b_hold"}, 32'(ok), 32'd1);
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_BREADY = 1'b0;
        check({tag, "_b_done"}, 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'b011);
        model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly, input string tag);
        int k = 0, lat = 0, w;
        bit ok = 1;
        logic [31:0] d0, mask;
        logic [1:0] r0;
        @(negedge clk);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ar_hs"}, 32'(k < 40), 32'd1);
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        check({tag, "_arready_drop"}, 32'(S_AXI_ARREADY), 32'd0);
        while (!S_AXI_RVALID && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_r_lat"}, 32'(lat), 32'(RD_LAT));
        check({tag, "_rresp"}, 32'(S_AXI_RRESP), in_range(addr) ? 32'd0 : 32'd2);
        if (in_range(addr)) begin
            w = word_of(addr);
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{model_bv[w][i]}};
            check({tag, "_rdata"}, S_AXI_RDATA & mask, model_mem[w] & mask);
        end else begin
            check({tag, "_rdata_err"}, S_AXI_RDATA, 32'h0);
        end
        d0 = S_AXI_RDATA;
        r0 = S_AXI_RRESP;
        repeat (r_dly) begin
            @(negedge clk);
            if (!(S_AXI_RVALID && S_AXI_RDATA == d0 && S_AXI_RRESP == r0 && !S_AXI_ARREADY)) ok = 0;
        end
        check({tag, "_r_hold"}, 32'(ok), 32'd1);
        S_AXI_RREADY = 1'b1;
        @(negedge clk);
        S_AXI_RREADY = 1'b0;
        check({tag, "_r_done"}, 32'({S_AXI_RVALID, S_AXI_ARREADY}), 32'b01);
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        reset = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_bv[i] = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'b111);
        check("reset_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'b00);
        check("reset_resp", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'h0);
        check("reset_rdata", S_AXI_RDATA, 32'h0);

        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, "wr_full");
        axi_read(32'h10, 0, "rd_full");
        axi_write(32'h10, 32'h0000AB00, 4'b0010, 3, 0, 0, "wr_w_first");
        axi_read(32'h10, 0, "rd_lane1");
        check("lane1_model", model_mem[4], 32'hDEADABEF);
        axi_write(32'h14, 32'h01020304, 4'hF, 0, 0, 5, "wr_bstall");
        axi_write(32'h0, 32'h12345678, 4'hF, 1, 0, 0, "wr_word0");
        axi_read(32'h0000_1000, 0, "rd_oob");
        axi_write(32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_oob");
        axi_read(32'h0, 0, "rd_word0");
        axi_read(32'h16, 2, "rd_rstall");

`ifndef AXI_SLV_WAIT_EN
        // Same-edge read and write of one word: read must see the old value
        axi_write(32'h20, 32'hA5A5_0001, 4'hF, 0, 0, 0, "wr_coll_pre");
        @(negedge clk);
        S_AXI_AWADDR = 32'h20; S_AXI_WDATA = 32'h5A5A_0002; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h20; S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        check("coll_valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'b11);
        check("coll_old_data", S_AXI_RDATA, 32'hA5A5_0001);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge clk);
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        model_write(32'h20, 32'h5A5A_0002, 4'hF);
        axi_read(32'h20, 0, "rd_coll_new");
`endif

        // Reset with a write response and a read beat both pending
        @(negedge clk);
        S_AXI_AWADDR = 32'h40; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", 32'(S_AXI_BVALID), 32'd1);
        model_write(32'h40, 32'hCAFE_F00D, 4'hF);
        S_AXI_ARADDR = 32'h40; S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        lat = 0;
        while (!S_AXI_RVALID && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("pre_rst_rvalid", 32'(S_AXI_RVALID), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'b111);
        check("mid_rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'b00);
        check("mid_rst_resp", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'h0);
        check("mid_rst_rdata", S_AXI_RDATA, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        axi_read(32'h40, 0, "rd_after_rst");
        axi_read(32'h0, 0, "rd_word0_kept");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'h1000 + 32'($urandom_range(0, 255));
            else
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
            else
                axi_read(a, $urandom_range(0, 3), "rnd_rd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
